// File: rtl/xy_switch_allocator.sv
// xy_switch_allocator: XY-routed five-port switch allocator for one virtual channel.
// Rev 1.0 - round-robin per output, one-deep registered output stage, optional U-turn drop.
`default_nettype none

module xy_switch_allocator #(
   parameter int DATA_W     = 64,
   parameter int HOP_W      = 4,
   parameter int DIR_X_BIT  = 62,
   parameter int DIR_Y_BIT  = 61,
   parameter int HOP_X_LO   = 52,
   parameter int HOP_Y_LO   = 48,
   parameter int UTURN_DROP = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic [4:0]          in_valid,
   input  logic [5*DATA_W-1:0] in_data,
   output logic [4:0]          in_pop,
   output logic [4:0]          out_valid,
   output logic [5*DATA_W-1:0] out_data,
   input  logic [4:0]          out_ready,
   output logic [4:0]          uturn_err
);

   localparam logic [HOP_W-1:0] HOP_ONE = {{(HOP_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] w_flit [5];
   logic [DATA_W-1:0] w_mod  [5];
   logic [2:0]        w_tgt  [5];
   logic [4:0]        w_uturn;
   logic [4:0]        w_req  [5];
   logic [4:0]        w_free;
   logic [4:0]        w_ogrant;
   logic [2:0]        w_gsel [5];
   logic [2:0]        w_idx;
   logic [4:0]        w_pop;

   logic [DATA_W-1:0] r_od   [5];
   logic [4:0]        r_ov;
   logic [2:0]        r_ptr  [5];
   logic [4:0]        r_uerr;

   function automatic logic [2:0] wrap5(input logic [3:0] s);
      return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
   endfunction

   genvar g;
   generate
      for (g = 0; g < 5; g++) begin : g_port
         assign w_flit[g]                     = in_data[g*DATA_W +: DATA_W];
         assign out_data[g*DATA_W +: DATA_W]  = r_od[g];
      end
   endgenerate

   // X dimension first, then Y, else eject to PE; only a nonzero field is decremented.
   always_comb begin
      for (int p = 0; p < 5; p++) begin
         w_mod[p] = w_flit[p];
         w_tgt[p] = 3'd4;
         if (w_flit[p][HOP_X_LO +: HOP_W] != '0) begin
            w_tgt[p] = w_flit[p][DIR_X_BIT] ? 3'd2 : 3'd3;
            w_mod[p][HOP_X_LO +: HOP_W] = w_flit[p][HOP_X_LO +: HOP_W] - HOP_ONE;
         end else if (w_flit[p][HOP_Y_LO +: HOP_W] != '0) begin
            w_tgt[p] = w_flit[p][DIR_Y_BIT] ? 3'd0 : 3'd1;
            w_mod[p][HOP_Y_LO +: HOP_W] = w_flit[p][HOP_Y_LO +: HOP_W] - HOP_ONE;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 5; p++) begin
         w_uturn[p] = (UTURN_DROP != 0) && (p < 4) && in_valid[p] && (w_tgt[p] == 3'(p));
      end
      for (int o = 0; o < 5; o++) begin
         w_free[o] = !r_ov[o] || out_ready[o];
         for (int p = 0; p < 5; p++) begin
            w_req[o][p] = in_valid[p] && !w_uturn[p] && (w_tgt[p] == 3'(o));
         end
      end
   end

   // Round-robin search from r_ptr[o], wrapping modulo 5.
   always_comb begin
      w_idx    = '0;
      w_ogrant = '0;
      w_pop    = w_uturn & {5{en}};
      for (int o = 0; o < 5; o++) begin
         w_gsel[o] = '0;
         if (en && w_free[o]) begin
            for (int i = 0; i < 5; i++) begin
               w_idx = wrap5({1'b0, r_ptr[o]} + 4'(i));
               if (!w_ogrant[o] && w_req[o][w_idx]) begin
                  w_ogrant[o]   = 1'b1;
                  w_gsel[o]     = w_idx;
                  w_pop[w_idx]  = 1'b1;
               end
            end
         end
      end
   end

   assign in_pop    = reset_n ? w_pop : 5'b0;
   assign out_valid = r_ov;
   assign uturn_err = r_uerr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ov   <= '0;
         r_uerr <= '0;
         for (int o = 0; o < 5; o++) begin
            r_od[o]  <= '0;
            r_ptr[o] <= '0;
         end
      end else begin
         if (en) begin
            r_uerr <= r_uerr | w_uturn;
         end
         for (int o = 0; o < 5; o++) begin
            if (w_ogrant[o]) begin
               r_od[o]  <= w_mod[w_gsel[o]];
               r_ov[o]  <= 1'b1;
               r_ptr[o] <= wrap5({1'b0, w_gsel[o]} + 4'd1);
            end else if (out_ready[o]) begin
               r_ov[o]  <= 1'b0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/xy_switch_allocator.md
Name: xy_switch_allocator

Overview:
- Parametrised, registered successor to the per-VC four-way arbitrator.
- Serves one virtual channel of a mesh router with five fixed ports, indexed 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT, 4=PE.
- Decodes XY dimension-order routing from the hop fields, decrements the hop count, and runs one round-robin arbiter per output.
- Each output has a one-deep registered stage with valid/ready handshake. Optional U-turn filtering drops misrouted flits and records a sticky error.

Parameters:
- DATA_W, 64: flit width in bits.
- HOP_W, 4: width of each unsigned hop field.
- DIR_X_BIT, 62: X direction bit; 1=LEFT, 0=RIGHT.
- DIR_Y_BIT, 61: Y direction bit; 1=UP, 0=DOWN.
- HOP_X_LO, 52: LSB of the X hop field; field is HOP_W bits.
- HOP_Y_LO, 48: LSB of the Y hop field; field is HOP_W bits.
- UTURN_DROP, 1: 1 enables U-turn filtering on ports 0-3.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  allocator active this cycle (VC slot select).
- in_valid  in  5  per-input flit present.
- in_data  in  5*DATA_W  flit of port p at [p*DATA_W +: DATA_W].
- in_pop  out  5  combinational; consume the head flit of input p this cycle.
- out_valid  out  5  registered output flit valid.
- out_data  out  5*DATA_W  registered output flits, with hop field already decremented.
- out_ready  in  5  downstream accepts out_data[o] this cycle.
- uturn_err  out  5  sticky per-input U-turn drop flag; bit 4 is always 0.

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0, out_data=0, uturn_err=0.
  - All round-robin pointers = 0, so UP has highest priority.
  - in_pop is combinational and is 0 while reset_n=0.
- Route decode (combinational, per valid input):
  - X hop != 0 → target LEFT or RIGHT per DIR_X_BIT; X hop decremented by 1.
  - Else Y hop != 0 → target UP or DOWN per DIR_Y_BIT; Y hop decremented by 1.
  - Else → target PE, flit unmodified.
  - All other bits pass through unchanged. Hop arithmetic is unsigned HOP_W and never underflows, because only nonzero fields are decremented.
- U-turn:
  - Applies when UTURN_DROP=1 and input p in 0..3 targets output p.
  - Request is masked; in_pop[p]=1 when en=1 (flit dropped); uturn_err[p] set at the next edge; no output is written.
  - PE→PE loopback is legal.
- Output slot free (per output o): out_valid[o]=0, or out_valid[o]&out_ready[o] (same-cycle drain and refill is allowed).
- Arbitration:
  - Occurs when en=1 and slot o is free.
  - Requesters are the unmasked inputs targeting o.
  - Search order starts at ptr[o] and wraps modulo 5; the first requester wins.
- On a grant to input k:
  - in_pop[k]=1 in the same cycle.
  - At the next edge: out_data[o] = the modified flit, out_valid[o]=1, ptr[o] = (k+1) mod 5.
  - The pointer does not change without a grant.
- Latency and throughput:
  - in_valid to out_valid is 1 cycle.
  - Throughput is 1 flit/cycle/output with continuous out_ready.
- Conflicts: each input targets exactly one output, so in_pop has no multi-grant conflicts. Non-winning inputs hold; in_pop=0.
- Backpressure: out_valid=1 & out_ready=0 → out_data and out_valid hold. No arbitration for that output; its requesters stall.
- Drain: out_valid&out_ready with no new grant → out_valid=0 next cycle.
- en=0:
  - No grants, no drops, in_pop=0.
  - Pointers and uturn_err hold.
  - Output registers still drain on out_ready.
- Ignored inputs: in_valid=0 inputs are ignored regardless of in_data.
- uturn_err clears only on reset.
- Reset mid-operation: pending output flits are discarded and pointers return to 0.

Test Plan:
- Reset and single flit: reset_n low 3 cycles → all outputs 0. Release; PE input valid with X hop=3, DIR_X=0 → in_pop=5'b10000 that cycle; next cycle out_valid[3]=1, out_data X hop=2, other bits equal.
- Fairness: LEFT, RIGHT and PE inputs all held valid with hops 0 (target PE), out_ready=1 → grants rotate 2,3,4,2,3,4; out_valid[4] high every cycle.
- Backpressure: out_ready[0]=0 with flit held, UP-bound flit waiting on DOWN input → out_data[0] stable and in_pop[1]=0. Raise out_ready → same-cycle pop and refill; out_valid[0] stays 1.
- U-turn: LEFT input, X hop=1, DIR_X=1 (target LEFT) → in_pop[2]=1, no out_valid, uturn_err=5'b00100 sticky. With UTURN_DROP=0 the flit is delivered to out[2].
- Y routing and enable: X hop=0, Y hop=2, DIR_Y=1 with en=0 for 2 cycles → no pop. Set en=1 → out[0] gets Y hop=1.
- Async reset mid-stream: assert reset_n between edges while out_valid=5'b11111 → outputs clear immediately; the first grant after release goes to the lowest-index requester.
